// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared wave-processing constants and FSM state encoding
package wave_pkg;

  localparam int WAVE_WIDTH  = 8;
  localparam int DIFF_OFFSET = 128;

  // Same encoding as the differentiator's IDLE/LOAD_WAVE pair
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1
  } wave_state_t;

endpackage

// File: rtl/wave_sat_add.sv
// rtl/wave_sat_add.sv - integrator step acc - (diff - offset), wrapped or clamped
// Clamps to 0..2^WAVE_WIDTH-1 when WAVE_INTEG_SAT_EN is defined, otherwise wraps modulo 2^WAVE_WIDTH.
module wave_sat_add #(
  parameter int WAVE_WIDTH  = wave_pkg::WAVE_WIDTH,
  parameter int DIFF_OFFSET = wave_pkg::DIFF_OFFSET
) (
  input  logic [WAVE_WIDTH-1:0] acc,
  input  logic [WAVE_WIDTH-1:0] diff_data,
  output logic [WAVE_WIDTH-1:0] sum,
  output logic                  out_of_range
);
  import wave_pkg::*;

  localparam logic [WAVE_WIDTH:0] OFFS = (WAVE_WIDTH+1)'(DIFF_OFFSET);

  logic [WAVE_WIDTH:0]   delta;
  logic [WAVE_WIDTH+1:0] next_val;

  // Two guard bits: top bit is the sign, the next one flags results above full scale
  assign delta        = {1'b0, diff_data} - OFFS;
  assign next_val     = {2'b00, acc} - {delta[WAVE_WIDTH], delta};
  assign out_of_range = next_val[WAVE_WIDTH+1] | next_val[WAVE_WIDTH];

`ifdef WAVE_INTEG_SAT_EN
  always_comb begin
    sum = next_val[WAVE_WIDTH-1:0];
    if (next_val[WAVE_WIDTH+1])
      sum = '0;
    else if (next_val[WAVE_WIDTH])
      sum = '1;
  end
`else
  assign sum = next_val[WAVE_WIDTH-1:0];
`endif

endmodule

// File: rtl/wave_integrator.sv
// rtl/wave_integrator.sv - rebuilds a waveform from an offset-binary difference stream
// Saturation versus wrap is selected inside wave_sat_add by WAVE_INTEG_SAT_EN.
module wave_integrator #(
  parameter int WAVE_WIDTH  = wave_pkg::WAVE_WIDTH,
  parameter int CNT_WIDTH   = 10,
  parameter int DIFF_OFFSET = wave_pkg::DIFF_OFFSET
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [WAVE_WIDTH-1:0] diff_data,
  input  logic [WAVE_WIDTH-1:0] seed_data,
  output logic [WAVE_WIDTH-1:0] wave_dout,
  output logic                  output_valid,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic                  sat_flag
);
  import wave_pkg::*;

  wave_state_t           state;
  logic [WAVE_WIDTH-1:0] acc;
  logic [WAVE_WIDTH-1:0] step_sum;
  logic                  step_oor;

  wave_sat_add #(
    .WAVE_WIDTH  (WAVE_WIDTH),
    .DIFF_OFFSET (DIFF_OFFSET)
  ) u_sat_add (
    .acc          (acc),
    .diff_data    (diff_data),
    .sum          (step_sum),
    .out_of_range (step_oor)
  );

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      wave_dout    <= '0;
      output_valid <= 1'b0;
      sample_cnt   <= '0;
      sat_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          output_valid <= 1'b0;
          // The diff on the seed cycle is dropped: the differentiator emits nothing for its first sample
          if (valid) begin
            acc      <= seed_data;
            sat_flag <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (valid) begin
            acc          <= step_sum;
            wave_dout    <= step_sum;
            output_valid <= 1'b1;
            sample_cnt   <= sample_cnt + 1'b1;
            if (step_oor)
              sat_flag <= 1'b1;
          end else begin
            output_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          output_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_integrator.sv
// tb/tb_wave_integrator.sv - directed scoreboard bench for wave_integrator
module tb_wave_integrator;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       valid   = 1'b0;
  logic [7:0] diff_data = '0;
  logic [7:0] seed_data = '0;
  logic [7:0] wave_dout;
  logic       output_valid;
  logic [9:0] sample_cnt;
  logic       sat_flag;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];
  int samp[64];

  always #10 clk_50M = ~clk_50M;

  wave_integrator dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .valid        (valid),
    .diff_data    (diff_data),
    .seed_data    (seed_data),
    .wave_dout    (wave_dout),
    .output_valid (output_valid),
    .sample_cnt   (sample_cnt),
    .sat_flag     (sat_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int val);
    exp_q.push_back(val[7:0]);
    exp_cnt = (exp_cnt + 1) % 1024;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic tick(input logic v, input logic [7:0] d, input logic [7:0] s);
    logic [7:0] e;
    @(negedge clk_50M);
    valid = v;
    diff_data = d;
    seed_data = s;
    @(posedge clk_50M);
    #1;
    if (output_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_valid", 32'(output_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wave_dout", 32'(wave_dout), 32'(e));
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("missing_output_valid", 32'(output_valid), 32'd1);
    end
  endtask

  initial begin
    int sat_hi;
    int sat_lo;
    for (int k = 0; k < 64; k++)
      samp[k] = int'(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
`ifdef WAVE_INTEG_SAT_EN
    sat_hi = 255;
    sat_lo = 0;
`else
    sat_hi = 22;
    sat_lo = 249;
`endif

    // Reset state
    rst_n = 1'b0;
    tick(1'b1, 8'd0, 8'd77);
    tick(1'b0, 8'd0, 8'd0);
    chk("rst_wave_dout", 32'(wave_dout), 32'd0);
    chk("rst_output_valid", 32'(output_valid), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    rst_n = 1'b1;
    tick(1'b0, 8'd0, 8'd0);
    chk("idle_output_valid", 32'(output_valid), 32'd0);

    // Basic reconstruction
    tick(1'b1, 8'd5, 8'd100);
    chk("seed_output_valid", 32'(output_valid), 32'd0);
    push(100); tick(1'b1, 8'd128, 8'd0);
    push(110); tick(1'b1, 8'd118, 8'd0);
    push(100); tick(1'b1, 8'd138, 8'd0);
    tick(1'b0, 8'd0, 8'd0);
    chk("basic_end_output_valid", 32'(output_valid), 32'd0);
    chk("basic_sample_cnt", 32'(sample_cnt), 32'd3);
    chk("basic_sat_flag", 32'(sat_flag), 32'd0);
    chk("hold_wave_dout", 32'(wave_dout), 32'd100);

    // Overflow
    tick(1'b1, 8'd0, 8'd250);
    push(sat_hi); tick(1'b1, 8'd100, 8'd0);
    chk("ovf_sat_flag", 32'(sat_flag), 32'd1);
    tick(1'b0, 8'd0, 8'd0);

    // Underflow
    tick(1'b1, 8'd0, 8'd5);
    push(sat_lo); tick(1'b1, 8'd140, 8'd0);
    chk("unf_sat_flag", 32'(sat_flag), 32'd1);
    tick(1'b0, 8'd0, 8'd0);
    chk("unf_sat_sticky_in_idle", 32'(sat_flag), 32'd1);

    // Gap and re-seed
    tick(1'b1, 8'd0, 8'd50);
    chk("reseed_sat_clear", 32'(sat_flag), 32'd0);
    push(50); tick(1'b1, 8'd128, 8'd0);
    push(50); tick(1'b1, 8'd128, 8'd0);
    tick(1'b0, 8'd128, 8'd0);
    chk("gap_output_valid", 32'(output_valid), 32'd0);
    tick(1'b1, 8'd90, 8'd200);
    chk("gap_seed_output_valid", 32'(output_valid), 32'd0);
    chk("gap_seed_sat_flag", 32'(sat_flag), 32'd0);
    push(201); tick(1'b1, 8'd127, 8'd0);
    tick(1'b0, 8'd0, 8'd0);
    chk("gap_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Loopback: differentiator output of a 64-sample sine
    tick(1'b1, 8'd0, 8'(samp[0]));
    for (int k = 1; k < 64; k++) begin
      push(samp[k]);
      tick(1'b1, 8'((samp[k-1] - samp[k] + 128) & 255), 8'd0);
    end
    tick(1'b0, 8'd0, 8'd0);
    chk("loop_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
    chk("loop_sat_flag", 32'(sat_flag), 32'd0);

    // Long periodic burst forces the sample counter through its wrap
    tick(1'b1, 8'd0, 8'(samp[0]));
    for (int k = 1; k <= 1024; k++) begin
      push(samp[k % 64]);
      tick(1'b1, 8'((samp[(k-1) % 64] - samp[k % 64] + 128) & 255), 8'd0);
    end
    tick(1'b0, 8'd0, 8'd0);
    chk("wrap_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Reset mid-burst at the 5th output
    tick(1'b1, 8'd0, 8'd10);
    for (int k = 0; k < 5; k++) begin
      push(10 + k + 1);
      tick(1'b1, 8'd127, 8'd0);
    end
    rst_n = 1'b0;
    tick(1'b1, 8'd127, 8'd0);
    chk("mid_rst_wave_dout", 32'(wave_dout), 32'd0);
    chk("mid_rst_output_valid", 32'(output_valid), 32'd0);
    chk("mid_rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("mid_rst_sat_flag", 32'(sat_flag), 32'd0);
    exp_cnt = 0;
    rst_n = 1'b1;
    tick(1'b1, 8'd0, 8'd60);
    chk("post_rst_seed_output_valid", 32'(output_valid), 32'd0);
    push(58); tick(1'b1, 8'd130, 8'd0);
    tick(1'b0, 8'd0, 8'd0);
    chk("post_rst_sample_cnt", 32'(sample_cnt), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wave_integrator.md
# wave_integrator

Reconstructs a sampled waveform from the offset-binary first-difference stream produced by the team's differentiator stage. Each difference sample encodes `prev - cur + 128`. The block inverts this with a seeded running accumulator: `cur = prev - (diff - 128)`. It sits downstream of the differentiator (loopback check, or the decode path after difference-coded transport) in the 50 MHz wave-processing domain.

## Interface
Parameters:
- `WAVE_WIDTH`, default 8: sample width, for both the difference input and the reconstructed output.
- `CNT_WIDTH`, default 10: width of the sample counter.
- `DIFF_OFFSET`, default 128: zero-difference code.

Ports:
- `clk_50M`, in, 1: single clock, 50 MHz.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `valid`, in, 1: `diff_data` is valid this cycle. Held high for a burst.
- `diff_data`, in, WAVE_WIDTH: offset-binary difference sample.
- `seed_data`, in, WAVE_WIDTH: absolute starting sample, captured at burst start.
- `wave_dout`, out, WAVE_WIDTH: reconstructed sample (registered).
- `output_valid`, out, 1: `wave_dout` is new this cycle.
- `sample_cnt`, out, CNT_WIDTH: count of accepted difference samples. Wraps.
- `sat_flag`, out, 1: sticky for the current burst. Set when any result left 0..2^WAVE_WIDTH-1; behaviour depends on the macro.

## Operation
- States:
  - IDLE: waiting for a burst.
  - ACCUM: integrating.
  - Unused encodings go to IDLE and clear `output_valid`.
- In IDLE:
  - If `valid`=0: hold everything; `output_valid`=0.
  - If `valid`=1: `acc <= seed_data`, `sat_flag <= 0`, go to ACCUM, `output_valid <= 0`.
  - The `diff_data` present on this cycle is ignored. It is the seed slot, mirroring the differentiator, which emits nothing for its first sample.
- In ACCUM, when `valid`=1:
  - `delta = diff_data - DIFF_OFFSET`, 9-bit signed, range -128..+127.
  - `next = acc - delta`, 10-bit signed, range -127..+383.
  - `acc <= wave_dout <= fix(next)`, `output_valid <= 1`, `sample_cnt <= sample_cnt + 1`.
- In ACCUM, when `valid`=0: go to IDLE, `output_valid <= 0`. `acc`, `wave_dout` and `sample_cnt` hold.
- `fix()` is defined under Configuration. `sat_flag <= 1` whenever `next` < 0 or `next` > 255.
- `sample_cnt` counts only ACCUM updates. It wraps 1023→0 and is never cleared except by reset.
- Re-raising `valid` after a gap always re-seeds: it is a new burst.

## Timing
- Reset values: `wave_dout`=0, `output_valid`=0, `sample_cnt`=0, `sat_flag`=0, `acc`=0, state=IDLE.
- Latency: difference sample at cycle N (in ACCUM) produces `wave_dout` and `output_valid`=1 at cycle N+1.
- The first output of a burst appears 2 cycles after `valid` rises. The seed cycle produces no output.
- Throughput: one sample per cycle with no stall. There is no backpressure; the consumer must accept every `output_valid`.
- `valid` low for a single cycle: `output_valid` is 0 in the following cycle, and the next high cycle is a seed slot.
- `rst_n` low mid-burst: all outputs return to reset values on the next edge, regardless of `valid`.

## Configuration
- `WAVE_INTEG_SAT_EN` defined: `fix(next)` clamps to 0 (if `next` < 0) or to 255 (if `next` > 255). Use this for display and analysis paths.
- `WAVE_INTEG_SAT_EN` undefined: `fix(next)` = `next` mod 256. This exactly inverts the differentiator's modulo-256 arithmetic, for bit-exact loopback.
- `sat_flag` behaves identically in both builds.

## Structure
- Shared package `wave_pkg` holds:
  - `WAVE_WIDTH`, `DIFF_OFFSET`.
  - State encoding constants IDLE=0, ACCUM=1. These are shared with the differentiator's IDLE/LOAD_WAVE encoding.
- Sub-module `wave_sat_add`: combinational; takes `acc` and `diff_data`, returns `fix(next)` and an out-of-range bit.
  - It contains the `WAVE_INTEG_SAT_EN` conditional, so the top level stays macro-free.
- The top level holds the FSM, the registers and the counter.

## Test plan
- Basic reconstruction: seed 100, then diffs 128, 118, 138. Outputs must be 100, 110, 100; `sample_cnt`=3; `sat_flag`=0.
- Overflow: seed 250, then diff 100. With the macro, output is 255 and `sat_flag`=1; without it, output is 22 and `sat_flag`=1.
- Underflow: seed 5, then diff 140. With the macro, output is 0; without it, output is 249; `sat_flag`=1 in both.
- Gap and re-seed: burst seed 50 with diffs 128 and 128, then `valid` low for 1 cycle, then a burst seeded at 200 with diff 127.
  - `output_valid` must be 0 during the gap and during the seed cycle.
  - The next output must be 201, and `sat_flag` must be cleared at the re-seed.
- Loopback, macro undefined: a 64-sample sine (0..255) is fed through the differentiator into this block, with the seed set to the first sample. Output must equal samples 2..64 bit-exactly. `sample_cnt` must wrap correctly after 1024 samples.
- Reset mid-burst: assert `rst_n`=0 at the 5th output. All outputs must be 0 on the next edge, and the state must be IDLE after release.
